mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between instruction fetch (IF stage) and data access (MEM stage).

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter_tag_pipe.sv | 38 +++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types, constants and arbitration helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int unsigned c_addr_w   = 10;
  localparam int unsigned c_data_w   = 32;
  localparam int unsigned c_starve_w = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_D    = 2'd2
  } sel_t;

  // A starved fetch beats data; otherwise data has priority.
  function automatic sel_t arb_pick(input logic starved, input logic if_req,
                                    input logic d_req);
    sel_t sel;
    sel = SEL_NONE;
    if (starved && if_req) sel = SEL_IF;
    else if (d_req)        sel = SEL_D;
    else if (if_req)       sel = SEL_IF;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester handshakes, hazard stalls and RAM port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = c_addr_w,
  parameter int unsigned DATA_W = c_data_w
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              proto_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  stall_if, stall_mem, proto_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output stall_if, stall_mem, proto_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_tag_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : arb_tag_pipe
// Description : DEPTH-stage owner-tag shift register tracking in-flight reads.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  own_t tag_in,
  output own_t tag_out
);

  logic [2*DEPTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) r_pipe <= '0;
        else       r_pipe <= tag_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) r_pipe <= '0;
        else       r_pipe <= {r_pipe[2*DEPTH-3:0], tag_in};
      end
    end
  endgenerate

  assign tag_out = own_t'(r_pipe[2*DEPTH-1 -: 2]);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Single-port RAM arbiter between fetch and data with starvation bound.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = c_addr_w,
  parameter int unsigned DATA_W     = c_data_w,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);

  logic [c_starve_w-1:0] r_starve;
  logic                  r_proto_err;
  logic                  w_d_req;
  logic                  w_starved;
  logic                  w_if_gnt;
  logic                  w_d_gnt;
  sel_t                  w_sel;
  own_t                  w_tag_in;
  own_t                  w_tag_out;

  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_starved = (r_starve == c_starve_max);

  always_comb begin
    w_sel    = arb_pick(w_starved, bus.if_req, w_d_req);
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!reset) begin
      w_if_gnt = (w_sel == SEL_IF);
      w_d_gnt  = (w_sel == SEL_D);
    end
  end

  // A conflicting read+write is handled as a write, so it never gets a read tag.
  always_comb begin
    w_tag_in = OWN_NONE;
    if (w_if_gnt)                     w_tag_in = OWN_IF;
    else if (w_d_gnt && !bus.d_write) w_tag_in = OWN_D;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_if_gnt || !bus.if_req) begin
      r_starve <= '0;
    end else if (!w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          r_proto_err <= 1'b0;
    else if (bus.d_read && bus.d_write) r_proto_err <= 1'b1;
  end

  arb_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
  );

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.stall_if  = bus.if_req & ~w_if_gnt;
  assign bus.stall_mem = w_d_req & ~w_d_gnt;
  assign bus.proto_err = r_proto_err;

  assign bus.mem_en    = w_if_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_write;
  assign bus.mem_addr  = w_if_gnt ? bus.if_addr : bus.d_addr;
  assign bus.mem_wdata = bus.d_wdata;

  assign bus.if_valid  = (w_tag_out == OWN_IF);
  assign bus.d_valid   = (w_tag_out == OWN_D);
  assign bus.if_rdata  = bus.if_valid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_valid  ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench; READ_LAT=1 and READ_LAT=2 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset1;
  logic reset2;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t q_if1[$];
  exp_t q_d1[$];
  exp_t q_if2[$];
  exp_t e_mon;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .STARVE_MAX(3)) u_dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  // Behavioural read-first RAM shared by both instances; only dut1 writes.
  logic [31:0] ram [1024];
  logic [31:0] rd1, rd2a, rd2b;
  always @(posedge clk) begin
    if (cyc == 0) begin
      ram[5]  <= 32'hDEADBEEF;
      ram[6]  <= 32'hCAFE0006;
      ram[20] <= 32'hA5A50020;
    end else if (bus1.mem_en && bus1.mem_we) begin
      ram[bus1.mem_addr] <= bus1.mem_wdata;
    end
    if (bus1.mem_en) rd1  <= ram[bus1.mem_addr];
    if (bus2.mem_en) rd2a <= ram[bus2.mem_addr];
    rd2b <= rd2a;
  end
  assign bus1.mem_rdata = rd1;
  assign bus2.mem_rdata = rd2b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: valid with no outstanding read (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (bus1.if_valid) begin
      if (q_if1.size() == 0) unexpected("if1_valid");
      else begin
        e_mon = q_if1.pop_front();
        chk("if1_rdata", bus1.if_rdata, e_mon.data);
        chk("if1_cycle", cyc, e_mon.cyc);
      end
    end
    if (bus1.d_valid) begin
      if (q_d1.size() == 0) unexpected("d1_valid");
      else begin
        e_mon = q_d1.pop_front();
        chk("d1_rdata", bus1.d_rdata, e_mon.data);
        chk("d1_cycle", cyc, e_mon.cyc);
      end
    end
    if (bus2.if_valid) begin
      if (q_if2.size() == 0) unexpected("if2_valid");
      else begin
        e_mon = q_if2.pop_front();
        chk("if2_rdata", bus2.if_rdata, e_mon.data);
        chk("if2_cycle", cyc, e_mon.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    bus1.if_req = 1'b0; bus1.if_addr = '0;
    bus1.d_read = 1'b0; bus1.d_write = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
  endtask

  task automatic idle2();
    bus2.if_req = 1'b0; bus2.if_addr = '0;
    bus2.d_read = 1'b0; bus2.d_write = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pick_if;

    // Reset with every request asserted
    reset1 = 1'b1; reset2 = 1'b1;
    idle2();
    bus1.if_req = 1'b1; bus1.if_addr = 10'd5;
    bus1.d_read = 1'b1; bus1.d_write = 1'b1; bus1.d_addr = 10'd9; bus1.d_wdata = 32'h1;
    @(negedge clk);
    chk("rst_if_gnt", bus1.if_gnt, 0);
    chk("rst_d_gnt",  bus1.d_gnt,  0);
    chk("rst_mem_en", bus1.mem_en, 0);
    chk("rst_mem_we", bus1.mem_we, 0);
    tick();
    reset1 = 1'b0; reset2 = 1'b0;
    idle1();
    @(negedge clk);
    chk("post_rst_if_valid",  bus1.if_valid,  0);
    chk("post_rst_d_valid",   bus1.d_valid,   0);
    chk("post_rst_proto_err", bus1.proto_err, 0);
    chk("idle_mem_en",        bus1.mem_en,    0);
    chk("idle_stall_if",      bus1.stall_if,  0);
    chk("idle_stall_mem",     bus1.stall_mem, 0);

    // Single fetch
    tick();
    bus1.if_req = 1'b1; bus1.if_addr = 10'd5;
    q_if1.push_back('{32'hDEADBEEF, cyc + 1});
    @(negedge clk);
    chk("fetch_if_gnt",   bus1.if_gnt,   1);
    chk("fetch_stall_if", bus1.stall_if, 0);
    chk("fetch_mem_en",   bus1.mem_en,   1);
    chk("fetch_mem_we",   bus1.mem_we,   0);
    chk("fetch_mem_addr", 32'(bus1.mem_addr), 32'd5);
    tick();
    idle1();

    // Fetch and data contending: starvation forces IF every fourth cycle
    for (int i = 0; i < 8; i++) begin
      tick();
      bus1.if_req = 1'b1; bus1.if_addr = 10'd5;
      bus1.d_read = 1'b1; bus1.d_addr = 10'd20;
      pick_if = (i == 3) || (i == 7);
      if (pick_if) q_if1.push_back('{32'hDEADBEEF, cyc + 1});
      else         q_d1.push_back('{32'hA5A50020, cyc + 1});
      @(negedge clk);
      chk($sformatf("starve_if_gnt_%0d", i),    bus1.if_gnt,    pick_if);
      chk($sformatf("starve_d_gnt_%0d", i),     bus1.d_gnt,     !pick_if);
      chk($sformatf("starve_stall_if_%0d", i),  bus1.stall_if,  !pick_if);
      chk($sformatf("starve_stall_mem_%0d", i), bus1.stall_mem, pick_if);
    end
    tick();
    idle1();

    // Write then read-back of the same address
    tick();
    bus1.d_write = 1'b1; bus1.d_addr = 10'd9; bus1.d_wdata = 32'h0000_1234;
    @(negedge clk);
    chk("wr_d_gnt",     bus1.d_gnt,  1);
    chk("wr_mem_we",    bus1.mem_we, 1);
    chk("wr_mem_addr",  32'(bus1.mem_addr), 32'd9);
    chk("wr_mem_wdata", bus1.mem_wdata, 32'h0000_1234);
    tick();
    bus1.d_write = 1'b0; bus1.d_read = 1'b1;
    q_d1.push_back('{32'h0000_1234, cyc + 1});
    @(negedge clk);
    chk("rd_d_gnt",  bus1.d_gnt,  1);
    chk("rd_mem_we", bus1.mem_we, 0);
    tick();
    idle1();
    @(negedge clk);
    chk("idle2_mem_en",    bus1.mem_en,    0);
    chk("idle2_mem_we",    bus1.mem_we,    0);
    chk("idle2_stall_mem", bus1.stall_mem, 0);

    // Conflicting read+write: performed as a write, sticky error
    tick();
    bus1.d_read = 1'b1; bus1.d_write = 1'b1; bus1.d_addr = 10'd12; bus1.d_wdata = 32'h5555AAAA;
    @(negedge clk);
    chk("conf_d_gnt",  bus1.d_gnt,  1);
    chk("conf_mem_we", bus1.mem_we, 1);
    tick();
    idle1();
    @(negedge clk);
    chk("conf_proto_err", bus1.proto_err, 1);
    chk("conf_no_valid",  bus1.d_valid,   0);
    tick();
    bus1.d_read = 1'b1; bus1.d_addr = 10'd12;
    q_d1.push_back('{32'h5555AAAA, cyc + 1});
    tick();
    idle1();
    tick();
    @(negedge clk);
    chk("conf_proto_err_held", bus1.proto_err, 1);
    tick();
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    @(negedge clk);
    chk("conf_proto_err_clr", bus1.proto_err, 0);

    // READ_LAT=2: back-to-back fetches return in order two cycles later
    tick();
    bus2.if_req = 1'b1; bus2.if_addr = 10'd5;
    q_if2.push_back('{32'hDEADBEEF, cyc + 2});
    @(negedge clk);
    chk("lat2_gnt_a", bus2.if_gnt, 1);
    tick();
    bus2.if_addr = 10'd6;
    q_if2.push_back('{32'hCAFE0006, cyc + 2});
    @(negedge clk);
    chk("lat2_gnt_b", bus2.if_gnt, 1);
    tick();
    idle2();
    tick();
    tick();

    // READ_LAT=2: reset discards an in-flight read
    tick();
    bus2.if_req = 1'b1; bus2.if_addr = 10'd5;
    @(negedge clk);
    chk("lat2_rst_gnt", bus2.if_gnt, 1);
    tick();
    reset2 = 1'b1;
    @(negedge clk);
    chk("lat2_rst_cycle_gnt",    bus2.if_gnt, 0);
    chk("lat2_rst_cycle_mem_en", bus2.mem_en, 0);
    tick();
    reset2 = 1'b0;
    idle2();
    @(negedge clk);
    chk("lat2_flush_t2", bus2.if_valid, 0);
    tick();
    @(negedge clk);
    chk("lat2_flush_t3", bus2.if_valid, 0);

    tick();
    tick();
    @(negedge clk);
    chk("q_if1_drained", q_if1.size(), 0);
    chk("q_d1_drained",  q_d1.size(),  0);
    chk("q_if2_drained", q_if2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
